// File: rtl/logic_gate_unit.sv
// Clocked bitwise gate unit: applies one of eight gate functions per beat (pairwise) or folds a
// multi-beat packet into a single result (accumulate), with valid/ready on both sides.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_all_ones,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic {StIdle, StAccum} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_y_q;
    logic             out_all_ones_q;
    logic             out_zero_q;
    logic [CNT_W-1:0] out_beats_q;

    logic             in_fire;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] res;
    logic             emit;

    // Per-beat term: base gate of the operands, or operand A for NOT/BUF.
    function automatic logic [WIDTH-1:0] beat_term(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] t;
        unique case (op)
            3'd0, 3'd2: t = a & b;
            3'd1, 3'd3: t = a | b;
            3'd4, 3'd5: t = a ^ b;
            default:    t = a;
        endcase
        return t;
    endfunction

    // Fold a new term into the running accumulator; NOT/BUF keep only the latest term.
    function automatic logic [WIDTH-1:0] fold(input logic [2:0] op,
                                              input logic [WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] r;
        unique case (op)
            3'd0, 3'd2: r = acc & t;
            3'd1, 3'd3: r = acc | t;
            3'd4, 3'd5: r = acc ^ t;
            default:    r = t;
        endcase
        return r;
    endfunction

    function automatic logic is_inverted(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3) || (op == 3'd5) || (op == 3'd6);
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        op_sel = in_op;
        acc_d  = '0;
        cnt_d  = CntOne;
        emit   = 1'b0;
        term   = '0;
        if (state_q == StAccum) begin
            op_sel = op_q;
            term   = beat_term(op_q, in_a, in_b);
            acc_d  = fold(op_q, acc_q, term);
            cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
            emit   = in_fire && in_last;
        end else begin
            term  = beat_term(in_op, in_a, in_b);
            acc_d = term;
            emit  = in_fire && (!in_mode || in_last);
        end
        res = is_inverted(op_sel) ? ~acc_d : acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            cnt_q          <= '0;
            op_q           <= '0;
            out_valid_q    <= 1'b0;
            out_y_q        <= '0;
            out_all_ones_q <= 1'b0;
            out_zero_q     <= 1'b0;
            out_beats_q    <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (in_fire) begin
                unique case (state_q)
                    StIdle: begin
                        if (in_mode) begin
                            op_q    <= in_op;
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            state_q <= in_last ? StIdle : StAccum;
                        end
                    end
                    StAccum: begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        state_q <= in_last ? StIdle : StAccum;
                    end
                    default: state_q <= StIdle;
                endcase
            end
            // A new result overrides the clear above when both happen in one cycle.
            if (emit) begin
                out_valid_q    <= 1'b1;
                out_y_q        <= res;
                out_all_ones_q <= &res;
                out_zero_q     <= ~|res;
                out_beats_q    <= cnt_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_y        = out_y_q;
    assign out_all_ones = out_all_ones_q;
    assign out_zero     = out_zero_q;
    assign out_beats    = out_beats_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed scenarios plus random traffic, checked against a
// packet-level reference model. A second instance with a 2-bit beat counter covers saturation.
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_mode;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid, out_all_ones, out_zero;
    logic [7:0] out_y;
    logic [3:0] out_beats;
    logic       in_ready2, out_valid2, out_all_ones2, out_zero2;
    logic [7:0] out_y2;
    logic [1:0] out_beats2;

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_all_ones(out_all_ones), .out_zero(out_zero), .out_beats(out_beats)
    );

    logic_gate_unit #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
        .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
        .out_all_ones(out_all_ones2), .out_zero(out_zero2), .out_beats(out_beats2)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: open packet as a list of operand pairs, plus the expected output register.
    bit         pkt_open;
    logic [2:0] pkt_op;
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    bit         exp_valid;
    logic [7:0] exp_y;
    int         exp_n;

    logic [7:0] got_y[$];
    int         got_b4[$];
    int         got_b2[$];

    logic [7:0] sweep_exp[8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [7:0] bp_a[4]      = '{8'hF0, 8'h0F, 8'hFF, 8'h00};
    logic [7:0] bp_exp[4]    = '{8'h3C, 8'hC3, 8'h33, 8'hCC};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-packet result from the gate truth tables.
    function automatic logic [7:0] packet_result();
        logic [7:0] y;
        logic [7:0] t;
        y = 8'h00;
        for (int i = 0; i < pa.size(); i++) begin
            case (pkt_op)
                3'd0, 3'd2: t = pa[i] & pb[i];
                3'd1, 3'd3: t = pa[i] | pb[i];
                3'd4, 3'd5: t = pa[i] ^ pb[i];
                default:    t = pa[i];
            endcase
            if (i == 0) y = t;
            else case (pkt_op)
                3'd0, 3'd2: y = y & t;
                3'd1, 3'd3: y = y | t;
                3'd4, 3'd5: y = y ^ t;
                default:    y = t;
            endcase
        end
        if (pkt_op == 3'd2 || pkt_op == 3'd3 || pkt_op == 3'd5 || pkt_op == 3'd6) y = ~y;
        return y;
    endfunction

    task automatic finish_packet();
        exp_valid = 1'b1;
        exp_y     = packet_result();
        exp_n     = pa.size();
        pkt_open  = 1'b0;
    endtask

    task automatic model_accept();
        if (!pkt_open) begin
            pkt_op = in_op;
            pa.delete();
            pb.delete();
            pa.push_back(in_a);
            pb.push_back(in_b);
            if (!in_mode || in_last) finish_packet();
            else pkt_open = 1'b1;
        end else begin
            pa.push_back(in_a);
            pb.push_back(in_b);
            if (in_last) finish_packet();
        end
    endtask

    task automatic model_reset();
        pkt_open  = 1'b0;
        pa.delete();
        pb.delete();
        exp_valid = 1'b0;
        exp_y     = 8'h00;
        exp_n     = 0;
    endtask

    // One clock: inputs are already set; check in_ready, advance model, compare after the edge.
    task automatic step(output bit fired);
        bit ir;
        #1;
        ir    = !exp_valid || out_ready;
        fired = !rst && in_valid && ir;
        if (!rst) begin
            check_eq("in_ready", in_ready, ir);
            check_eq("in_ready_sat", in_ready2, ir);
            if (out_valid && out_ready) begin
                got_y.push_back(out_y);
                got_b4.push_back(int'(out_beats));
                got_b2.push_back(int'(out_beats2));
            end
        end
        if (rst) model_reset();
        else begin
            if (exp_valid && out_ready) exp_valid = 1'b0;
            if (fired) model_accept();
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("out_valid_sat", out_valid2, exp_valid);
        if (exp_valid) begin
            check_eq("out_y", out_y, exp_y);
            check_eq("out_y_sat", out_y2, exp_y);
            check_eq("out_all_ones", out_all_ones, exp_y == 8'hFF);
            check_eq("out_zero", out_zero, exp_y == 8'h00);
            check_eq("out_zero_sat", out_zero2, exp_y == 8'h00);
            check_eq("out_beats", out_beats, (exp_n > 15) ? 15 : exp_n);
            check_eq("out_beats_sat", out_beats2, (exp_n > 3) ? 3 : exp_n);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input bit mode, input bit last);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_mode  = mode;
        in_last  = last;
    endtask

    task automatic drain();
        bit f;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(f);
    endtask

    initial begin
        bit f;
        int idx;
        model_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset
        step(f);
        step(f);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_y", out_y, 8'h00);
        check_eq("rst_out_beats", out_beats, 4'd0);
        check_eq("rst_all_ones", out_all_ones, 1'b0);
        check_eq("rst_zero", out_zero, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Pairwise sweep of all ops
        got_y.delete(); got_b4.delete(); got_b2.delete();
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(op), 1'b0, 1'b0);
            step(f);
        end
        drain();
        check_eq("sweep_count", got_y.size(), 8);
        for (int i = 0; i < got_y.size() && i < 8; i++) begin
            check_eq("sweep_y", got_y[i], sweep_exp[i]);
            check_eq("sweep_beats", got_b4[i], 1);
        end

        // Accumulate AND then NAND
        for (int k = 0; k < 2; k++) begin
            got_y.delete(); got_b4.delete(); got_b2.delete();
            drive(1'b1, 8'hFF, 8'hF0, (k == 0) ? 3'd0 : 3'd2, 1'b1, 1'b0); step(f);
            drive(1'b1, 8'h3C, 8'hFF, 3'd1, 1'b0, 1'b0); step(f);
            drive(1'b1, 8'hF8, 8'h7F, 3'd4, 1'b1, 1'b1); step(f);
            drain();
            check_eq("acc_count", got_y.size(), 1);
            if (got_y.size() > 0) begin
                check_eq("acc_y", got_y[0], (k == 0) ? 8'h30 : 8'hCF);
                check_eq("acc_beats", got_b4[0], 3);
            end
        end
        drive(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b1);
        step(f);
        check_eq("single_y", out_y, 8'hFF);
        check_eq("single_all_ones", out_all_ones, 1'b1);
        check_eq("single_beats", out_beats, 4'd1);
        drain();

        // Backpressure on a pairwise XOR stream
        got_y.delete(); got_b4.delete(); got_b2.delete();
        idx = 0;
        drive(1'b1, bp_a[0], 8'hCC, 3'd4, 1'b0, 1'b0);
        step(f);
        if (f) idx++;
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            drive(1'b1, bp_a[idx], 8'hCC, 3'd4, 1'b0, 1'b0);
            step(f);
            if (f) idx++;
            check_eq("bp_hold_y", out_y, 8'h3C);
            check_eq("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && idx < 4; k++) begin
            drive(1'b1, bp_a[idx], 8'hCC, 3'd4, 1'b0, 1'b0);
            step(f);
            if (f) idx++;
        end
        drain();
        check_eq("bp_count", got_y.size(), 4);
        for (int i = 0; i < got_y.size() && i < 4; i++) check_eq("bp_order", got_y[i], bp_exp[i]);

        // Reset in the middle of an accumulate packet
        got_y.delete(); got_b4.delete(); got_b2.delete();
        drive(1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b0); step(f);
        drive(1'b1, 8'h44, 8'h08, 3'd1, 1'b1, 1'b0); step(f);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b1; step(f);
        rst = 1'b0;
        drive(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0); step(f);
        drain();
        check_eq("midrst_count", got_y.size(), 1);
        if (got_y.size() > 0) begin
            check_eq("midrst_y", got_y[0], 8'h0F);
            check_eq("midrst_beats", got_b4[0], 1);
        end

        // Beat counter saturation
        got_y.delete(); got_b4.delete(); got_b2.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h01, 8'h00, 3'd4, 1'b1, i == 4);
            step(f);
        end
        drain();
        check_eq("sat_count", got_y.size(), 1);
        if (got_y.size() > 0) begin
            check_eq("sat_y", got_y[0], 8'h01);
            check_eq("sat_beats2", got_b2[0], 3);
            check_eq("sat_beats4", got_b4[0], 5);
        end

        // Random traffic with occasional resets and backpressure
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), $urandom_range(0, 9) < 3);
            step(f);
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
